// File: rtl/disp_pkg.sv
// Shared definitions for the six-digit display sharing block.
//   CODE_BLANK  : digit code the per-digit decoders render as an unlit digit
//   DIGITS      : number of seven-segment digits on the board
//   CODE_W      : width of one digit code
//   DISP_W      : width of the packed six-digit bus ([3:0] = HEX0 ... [23:20] = HEX5)
//   DISP_BLANK  : whole display blank
//   disp_state_t: arbitration state (idle, owned by requester 0, owned by requester 1)
package disp_pkg;

  localparam int DIGITS = 6;
  localparam int CODE_W = 4;
  localparam int DISP_W = DIGITS * CODE_W;

  localparam logic [CODE_W-1:0] CODE_BLANK = 4'hA;
  localparam logic [DISP_W-1:0] DISP_BLANK = {DIGITS{CODE_BLANK}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } disp_state_t;

endpackage

// File: rtl/disp_share_arbiter_pwm_gate.sv
// Brightness gating for the shared display.
// A free-running frame counter (0 .. PWM_PERIOD-1) is compared with the
// requested brightness; the selected digits are shown while the counter is
// below the brightness and the display is blanked for the rest of the frame.
//   clk, rst        : clock, asynchronous active-low reset
//   sel             : selected six-digit codes from the arbiter
//   brightness      : on-cycles per frame (0 = dark, >= PWM_PERIOD = full)
//   digit_code      : registered, gated codes to the seven-segment decoders
module pwm_gate
  import disp_pkg::*;
#(
  parameter int PWM_PERIOD = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DISP_W-1:0] sel,
  input  logic [3:0]        brightness,
  output logic [DISP_W-1:0] digit_code
);

  logic [3:0] pwm_cnt;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt    <= '0;
      digit_code <= DISP_BLANK;
    end else begin
      pwm_cnt    <= (pwm_cnt == 4'(PWM_PERIOD - 1)) ? 4'd0 : pwm_cnt + 4'd1;
      // Counter never exceeds PWM_PERIOD-1, so brightness >= PWM_PERIOD is full on.
      digit_code <= (pwm_cnt < brightness) ? sel : DISP_BLANK;
    end
  end

endmodule

// File: rtl/disp_share_arbiter.sv
// Shares the six-digit seven-segment display between two requesters.
// Requester 1 has priority; a grant persists for at least HOLD_TICKS tick
// strobes. The owner's digits are latched into sel (live while the owner keeps
// requesting, frozen while it is only being held) and then brightness-gated.
//   clk, rst     : clock, asynchronous active-low reset
//   tick         : one-cycle strobe from the 1 Hz divider
//   req[1:0]     : level requests, req[1] wins
//   data0, data1 : requester digit codes ([3:0] = HEX0 ... [23:20] = HEX5)
//   brightness   : on-cycles per PWM frame
//   gnt[1:0]     : one-hot grant, 00 when idle
//   busy         : any grant active
//   digit_code   : gated codes to the six decoders
module disp_share_arbiter
  import disp_pkg::*;
#(
  parameter int HOLD_TICKS = 3,
  parameter int PWM_PERIOD = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [1:0]  req,
  input  logic [23:0] data0,
  input  logic [23:0] data1,
  input  logic [3:0]  brightness,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic [23:0] digit_code
);

  localparam int HOLD_W = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);

  disp_state_t       state;
  disp_state_t       next_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DISP_W-1:0] sel;
  logic              hold_done;
  logic              entering;

  assign hold_done = (hold_cnt == '0);
  // Any move into an owner state (from IDLE or a direct switch) reloads the hold.
  assign entering  = (next_state != state) && (next_state != IDLE);

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req[1])      next_state = OWN1;
        else if (req[0]) next_state = OWN0;
      end
      OWN0: begin
        if (hold_done) begin
          if (req[1])       next_state = OWN1;
          else if (!req[0]) next_state = IDLE;
        end
      end
      OWN1: begin
        if (hold_done) begin
          if (req[0])       next_state = OWN0;
          else if (!req[1]) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Reload wins over a coincident tick, so a grant always lasts HOLD_TICKS full ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     hold_cnt <= '0;
    else if (entering)            hold_cnt <= HOLD_W'(HOLD_TICKS);
    else if (next_state == IDLE)  hold_cnt <= '0;
    else if (tick && !hold_done)  hold_cnt <= hold_cnt - HOLD_W'(1);
  end

  // NOTE: sel is reset (not left uninitialised like a storage array) because
  // the display must show blanks from the first cycle after reset.
  // Keyed on next_state so the digits load on the same edge as the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel <= DISP_BLANK;
    end else begin
      unique case (next_state)
        OWN0:    if (req[0]) sel <= data0;
        OWN1:    if (req[1]) sel <= data1;
        default: sel <= DISP_BLANK;
      endcase
    end
  end

  assign gnt  = {state == OWN1, state == OWN0};
  assign busy = (state != IDLE);

  pwm_gate #(
    .PWM_PERIOD (PWM_PERIOD)
  ) u_pwm_gate (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .brightness (brightness),
    .digit_code (digit_code)
  );

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Scoreboard bench for disp_share_arbiter (default HOLD_TICKS=3, PWM_PERIOD=10).
// The driver applies one input vector per clock, advances a behavioural model
// of the sharing rules and pushes the expected outputs; a monitor pops and
// compares them half a cycle later.
module tb_disp_share_arbiter;
  import disp_pkg::*;

  localparam int HOLD = 3;
  localparam int PER  = 10;
  localparam logic [23:0] BLANK = 24'hAAAAAA;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [23:0] data0 = '0;
  logic [23:0] data1 = '0;
  logic [3:0]  brightness = '0;
  logic [1:0]  gnt;
  logic        busy;
  logic [23:0] digit_code;

  disp_share_arbiter #(
    .HOLD_TICKS (HOLD),
    .PWM_PERIOD (PER)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .req        (req),
    .data0      (data0),
    .data1      (data1),
    .brightness (brightness),
    .gnt        (gnt),
    .busy       (busy),
    .digit_code (digit_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  gnt;
    logic        busy;
    logic [23:0] code;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Behavioural model: who owns the display, ticks still owed, latched digits,
  // and position in the brightness frame (cycles since reset, modulo PER).
  int          m_owner;
  int          m_hold;
  logic [23:0] m_sel;
  int          m_phase;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_sel   = BLANK;
    m_phase = 0;
  endfunction

  function automatic void model_step(input logic [1:0] r, input logic t,
                                     input logic [23:0] d0, input logic [23:0] d1,
                                     input int br);
    exp_t        e;
    logic [23:0] shown;
    int          other;
    // Output shows the digits latched before this edge, gated by frame position.
    shown   = (m_phase < br) ? m_sel : BLANK;
    m_phase = (m_phase + 1) % PER;
    if (m_owner < 0) begin
      if (r[1])      begin m_owner = 1; m_hold = HOLD; end
      else if (r[0]) begin m_owner = 0; m_hold = HOLD; end
    end else if (m_hold > 0) begin
      if (t) m_hold = m_hold - 1;
    end else begin
      other = 1 - m_owner;
      if (r[other])        begin m_owner = other; m_hold = HOLD; end
      else if (!r[m_owner]) m_owner = -1;
    end
    if (m_owner < 0)          m_sel = BLANK;
    else if (r[m_owner])      m_sel = (m_owner == 1) ? d1 : d0;
    e.gnt  = (m_owner == 1) ? 2'b10 : (m_owner == 0) ? 2'b01 : 2'b00;
    e.busy = (m_owner >= 0);
    e.code = shown;
    sb_q.push_back(e);
  endfunction

  // One clock of stimulus; returns 2 time units after the active edge.
  task automatic step(input logic [1:0] r, input logic t, input logic [23:0] d0,
                      input logic [23:0] d1, input logic [3:0] br);
    req = r; tick = t; data0 = d0; data1 = d1; brightness = br;
    @(posedge clk);
    #1;
    model_step(r, t, d0, d1, int'(br));
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gnt"},  32'(gnt),        32'd0);
    check({tag, "_busy"}, 32'(busy),       32'd0);
    check({tag, "_code"}, 32'(digit_code), 32'(BLANK));
  endtask

  // Asynchronous reset between edges, after the monitor has drained the queue.
  task automatic async_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("rst_hold");
    rst = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("sb_gnt",  32'(gnt),        32'(mon_e.gnt));
        check("sb_busy", 32'(busy),       32'(mon_e.busy));
        check("sb_code", 32'(digit_code), 32'(mon_e.code));
      end
    end
  end

  initial begin
    logic [1:0]  r_r;
    logic [23:0] r_d0, r_d1;
    logic [3:0]  r_br;
    int          lit;

    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;

    // Basic grant, then release after the hold expires.
    step(2'b01, 1'b0, 24'hAAAAA5, 24'h0, 4'd15);
    check("basic_gnt", 32'(gnt), 32'h1);
    step(2'b01, 1'b0, 24'hAAAAA5, 24'h0, 4'd15);
    check("basic_code", 32'(digit_code), 32'hAAAAA5);
    step(2'b00, 1'b1, 24'h123456, 24'h0, 4'd15);
    step(2'b00, 1'b0, 24'h123456, 24'h0, 4'd15);
    step(2'b00, 1'b1, 24'h123456, 24'h0, 4'd15);
    step(2'b00, 1'b1, 24'h123456, 24'h0, 4'd15);
    check("held_gnt", 32'(gnt), 32'h1);
    check("held_code", 32'(digit_code), 32'hAAAAA5);
    step(2'b00, 1'b0, 24'h123456, 24'h0, 4'd15);
    check("release_gnt", 32'(gnt), 32'h0);
    step(2'b00, 1'b0, 24'h123456, 24'h0, 4'd15);
    check("release_code", 32'(digit_code), 32'(BLANK));

    // Simultaneous requests from idle: requester 1 wins.
    step(2'b11, 1'b0, 24'h111111, 24'h222222, 4'd15);
    check("priority_gnt", 32'(gnt), 32'h2);
    repeat (3) step(2'b00, 1'b1, 24'h0, 24'h0, 4'd15);
    repeat (2) step(2'b00, 1'b0, 24'h0, 24'h0, 4'd15);

    // Preemption only after the hold runs out; tick coincides with entry.
    step(2'b01, 1'b1, 24'h000001, 24'h999999, 4'd15);
    step(2'b01, 1'b1, 24'h000002, 24'h999999, 4'd15);
    repeat (3) step(2'b11, 1'b0, 24'h000003, 24'h999999, 4'd15);
    step(2'b11, 1'b1, 24'h000003, 24'h999999, 4'd15);
    check("preempt_wait_gnt", 32'(gnt), 32'h1);
    step(2'b11, 1'b1, 24'h000003, 24'h999999, 4'd15);
    check("preempt_last_tick_gnt", 32'(gnt), 32'h1);
    step(2'b11, 1'b0, 24'h000003, 24'h999999, 4'd15);
    check("preempt_gnt", 32'(gnt), 32'h2);

    // Brightness gating with requester 1 owning the display.
    repeat (3) step(2'b10, 1'b0, 24'h0, 24'hBCDE00, 4'd15);
    lit = 0;
    repeat (PER) begin
      step(2'b10, 1'b0, 24'h0, 24'hBCDE00, 4'd4);
      if (digit_code == 24'hBCDE00) lit++;
    end
    check("pwm_b4_lit", 32'(lit), 32'd4);
    repeat (PER) step(2'b10, 1'b0, 24'h0, 24'hBCDE00, 4'd0);
    repeat (PER) step(2'b10, 1'b0, 24'h0, 24'hBCDE00, 4'd12);

    // Reset in the middle of an OWN1 grant.
    async_reset();
    step(2'b10, 1'b0, 24'h0, 24'h654321, 4'd3);
    check("post_rst_gnt", 32'(gnt), 32'h2);
    repeat (PER) step(2'b10, 1'b0, 24'h0, 24'h654321, 4'd3);

    // Randomised traffic with sticky requests.
    r_r = 2'b00; r_d0 = 24'h0; r_d1 = 24'h0; r_br = 4'd7;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0)  r_r  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)  r_d0 = 24'($urandom);
      if ($urandom_range(0, 3) == 0)  r_d1 = 24'($urandom);
      if ($urandom_range(0, 15) == 0) r_br = 4'($urandom_range(0, 15));
      step(r_r, ($urandom_range(0, 3) == 0), r_d0, r_d1, r_br);
      if (i == 700) async_reset();
    end

    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_share_arbiter.md
# disp_share_arbiter

Controller that shares the board's six-digit seven-segment display between two requesters. Requester 0 carries status or state readout; requester 1 carries higher-priority messages such as "oPEn". The block grants the display with a minimum-hold policy, selects the owner's six 4-bit digit codes, and applies PWM brightness gating. Its registered `digit_code` output feeds the existing per-digit seven-segment decoders directly.

## Interface

Parameters:

- `HOLD_TICKS`, default 3: minimum number of `tick` strobes a grant persists. 0 means no minimum.
- `PWM_PERIOD`, default 10: length of the brightness PWM frame in `clk` cycles. Legal range 2–15.

Ports:

- `clk`  in  1  system clock (50 MHz)
- `rst`  in  1  reset, asynchronous, active-low
- `tick`  in  1  one-cycle enable strobe from the 1 Hz divider
- `req`  in  2  level requests; `req[1]` has priority over `req[0]`
- `data0`  in  24  requester 0 digit codes; `[3:0]` is HEX0 … `[23:20]` is HEX5
- `data1`  in  24  requester 1 digit codes, same packing as `data0`
- `brightness`  in  4  on-cycles per PWM frame; 0 = dark, ≥`PWM_PERIOD` = full
- `gnt`  out  2  one-hot grant (`00` when idle)
- `busy`  out  1  high while any grant is active
- `digit_code`  out  24  gated codes to the six decoders

## Operation

- States: IDLE, OWN0, OWN1. `gnt`/`busy` are decoded from the registered state.
- IDLE:
  - `req[1]` → OWN1.
  - else `req[0]` → OWN0.
  - else stay.
- On entry to OWNi: `hold_cnt` ← `HOLD_TICKS`.
- In OWNi with `hold_cnt` > 0:
  - Stay regardless of `req`.
  - `tick` decrements `hold_cnt`.
- In OWNi with `hold_cnt` = 0:
  - If the other request is high → switch directly to OWNother in one cycle, no IDLE cycle, and reload `hold_cnt`.
  - Else if `req[i]` is high → stay.
  - Else → IDLE.
- Same-cycle `tick` and state entry: the reload wins; the tick is not counted.
- Data latch (6×4-bit register `sel`):
  - While OWNi and `req[i]` is high: `sel` ← `data_i` every cycle (live).
  - While OWNi and `req[i]` is low (held owner): `sel` freezes.
  - In IDLE: `sel` is all `CODE_BLANK`.
- PWM:
  - `pwm_cnt` counts 0 … `PWM_PERIOD`−1, then wraps to 0.
  - It free-runs from reset and is independent of the arbitration state.
- Output gating: `digit_code` ← `sel` when `pwm_cnt` < `brightness`, else all `CODE_BLANK`.
- `CODE_BLANK` = 4'hA. No other code values are interpreted; codes pass through unchanged.

## Timing

- Reset values: state IDLE, `gnt`=00, `busy`=0, `hold_cnt`=0, `pwm_cnt`=0, `sel` and `digit_code` all 4'hA (24'hAAAAAA).
- Request to grant: `req` sampled at edge N → `gnt` valid after edge N (1 cycle).
- Grant to display: `sel` is loaded on the same edge as the grant; `digit_code` reflects it one edge later (2 cycles from request).
- Data change of the owner to `digit_code`: 2 cycles (`sel` then output register).
- Brightness change takes effect on the next PWM comparison (1-cycle latency). No frame alignment.
- Asynchronous reset mid-grant: all outputs return to reset values immediately. The first grant after reset deassertion follows the normal 1-cycle rule.
- `HOLD_TICKS`=0: release/switch is evaluated on the cycle after entry.

## Structure

- Package `disp_pkg` contains:
  - `CODE_BLANK` (4'hA)
  - `DIGITS` (6)
  - `CODE_W` (4)
  - state enum `disp_state_t` {IDLE, OWN0, OWN1}
- Sub-module `pwm_gate`:
  - Owns `pwm_cnt`, the compare, and the output register.
  - Inputs: `sel`, `brightness`. Output: `digit_code`.
- Top level holds the FSM, `hold_cnt`, and the `sel` latch.

## Test plan

- Reset check: hold `rst`=0 → `gnt`=00, `busy`=0, `digit_code`=24'hAAAAAA.
- Basic grant: `brightness`=15, `req`=01, `data0`=24'hAAAAA5 → `gnt`=01 after 1 cycle, `digit_code`=24'hAAAAA5 after 2 cycles. Drop `req` with `HOLD_TICKS`=3 → owner held and output frozen until the 3rd tick, then `gnt`=00 and output blanks.
- Priority on simultaneous request: `req`=11 from IDLE → `gnt`=10.
- Preemption after hold: `req1` raised while OWN0 at `hold_cnt`=2 → no switch until 2 ticks have elapsed, then `gnt` goes 01→10 in a single cycle.
- Tick/entry collision: `tick` coincides with grant entry → hold still lasts 3 full ticks.
- PWM brightness, `PWM_PERIOD`=10, `data1`=24'hBCDE00:
  - `brightness`=4 → exactly 4 of every 10 cycles show data, the other 6 are 24'hAAAAAA.
  - `brightness`=0 → always blank.
  - `brightness`=12 → always data.
- Reset mid-operation: async `rst` pulse mid-OWN1 → immediate reset values, `pwm_cnt` restarts at 0.
